dmac_channel_arbiter: RTL

DMAC_CHANNEL_ARBITER -- requirements
Module: dmac_channel_arbiter

---
 rtl/dmac_channel_arbiter.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/dmac_channel_arbiter.sv
// dmac_channel_arbiter: shares one AHB master port among NUM_CH DMA channels.
// Define DMAC_ARB_ROUND_ROBIN_EN for round-robin arbitration; default is fixed lowest-index priority.
module dmac_channel_arbiter #(
    parameter int NUM_CH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_CH-1:0]     ch_req,
    input  logic [2*NUM_CH-1:0]   ch_htrans,
    input  logic [32*NUM_CH-1:0]  ch_maddr,
    input  logic [32*NUM_CH-1:0]  ch_mwdata,
    input  logic [4*NUM_CH-1:0]   ch_mwstrb,
    input  logic [2*NUM_CH-1:0]   ch_mburst,
    input  logic [NUM_CH-1:0]     ch_write,
    input  logic [NUM_CH-1:0]     ch_irq,
    input  logic                  readyIn,
    input  logic [1:0]            M_HResp,
    output logic [NUM_CH-1:0]     ch_gnt,
    output logic [NUM_CH-1:0]     ch_ready,
    output logic [2*NUM_CH-1:0]   ch_hresp,
    output logic [1:0]            HTrans,
    output logic [31:0]           MAddress,
    output logic [31:0]           MWData,
    output logic [3:0]            MWStrb,
    output logic [1:0]            MBurst_Size,
    output logic                  write,
    output logic                  irq
);
    localparam int unsigned N  = NUM_CH;
    localparam int unsigned IW = $clog2(NUM_CH);

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] OWN      = 2'd1;
    localparam logic [1:0] HANDOVER = 2'd2;

    logic [1:0]    state;
    logic [N-1:0]  gnt;
    logic [IW-1:0] gnt_idx;
    logic [IW-1:0] dsel;
    logic [IW-1:0] win_idx;
    logic          win_found;
    logic          grant_now;
    logic          owner_done;

    logic [1:0]  htrans_a [N];
    logic [31:0] maddr_a  [N];
    logic [31:0] mwdata_a [N];
    logic [3:0]  mwstrb_a [N];
    logic [1:0]  mburst_a [N];

    for (genvar g = 0; g < NUM_CH; g++) begin : g_unpack
        assign htrans_a[g] = ch_htrans[2*g +: 2];
        assign maddr_a[g]  = ch_maddr[32*g +: 32];
        assign mwdata_a[g] = ch_mwdata[32*g +: 32];
        assign mwstrb_a[g] = ch_mwstrb[4*g +: 4];
        assign mburst_a[g] = ch_mburst[2*g +: 2];
    end

`ifdef DMAC_ARB_ROUND_ROBIN_EN
    logic [IW-1:0] ptr;

    // Search starts one past the last winner so the previous owner ranks last.
    always_comb begin : arb_rr
        int unsigned c;
        c         = 0;
        win_found = 1'b0;
        win_idx   = '0;
        for (int unsigned k = 1; k <= N; k++) begin
            c = (32'(ptr) + k) % N;
            if (!win_found && ch_req[IW'(c)]) begin
                win_found = 1'b1;
                win_idx   = IW'(c);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            ptr <= '0;
        else if (grant_now)
            ptr <= win_idx;
    end
`else
    always_comb begin : arb_fixed
        win_found = 1'b0;
        win_idx   = '0;
        for (int unsigned k = 0; k < N; k++) begin
            if (!win_found && ch_req[IW'(k)]) begin
                win_found = 1'b1;
                win_idx   = IW'(k);
            end
        end
    end
`endif

    assign grant_now  = win_found && ((state == IDLE) || (state == HANDOVER && readyIn));
    assign owner_done = !ch_req[gnt_idx] && (htrans_a[gnt_idx] == 2'b00);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            gnt     <= '0;
            gnt_idx <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_now) begin
                        gnt     <= {{(N-1){1'b0}}, 1'b1} << win_idx;
                        gnt_idx <= win_idx;
                        state   <= OWN;
                    end
                end
                OWN: begin
                    if (owner_done) begin
                        gnt   <= '0;
                        state <= HANDOVER;
                    end
                end
                HANDOVER: begin
                    if (grant_now) begin
                        gnt     <= {{(N-1){1'b0}}, 1'b1} << win_idx;
                        gnt_idx <= win_idx;
                        state   <= OWN;
                    end else if (readyIn) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    gnt   <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end

    // Data phase trails the accepted address phase by one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            dsel <= '0;
        else if (readyIn && HTrans != 2'b00)
            dsel <= gnt_idx;
    end

    always_comb begin
        HTrans      = 2'b00;
        MAddress    = '0;
        MBurst_Size = '0;
        write       = 1'b0;
        MWData      = '0;
        MWStrb      = '0;
        if (!rst) begin
            if (|gnt) begin
                HTrans      = htrans_a[gnt_idx];
                MAddress    = maddr_a[gnt_idx];
                MBurst_Size = mburst_a[gnt_idx];
                write       = ch_write[gnt_idx];
            end
            MWData = mwdata_a[dsel];
            MWStrb = mwstrb_a[dsel];
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_route
        assign ch_ready[g]       = !rst && readyIn && (gnt[g] || dsel == IW'(g));
        assign ch_hresp[2*g +: 2] = (!rst && dsel == IW'(g)) ? M_HResp : 2'b00;
    end

    assign ch_gnt = gnt;
    assign irq    = |ch_irq;
endmodule
